// File: rtl/msrh_cmt_tracker.sv
// Commit tracker for the msrh core: in-order retirement of dispatch groups,
// with per-slot done tracking, exception flush and old-rd release at commit.
module msrh_cmt_tracker #(
    parameter int DISP_SIZE      = 2,
    parameter int CMT_ENTRY_SIZE = 16,
    parameter int CMT_BUS_SIZE   = 2,
    parameter int RNID_W         = 6,
    localparam int CMT_ID_W      = $clog2(CMT_ENTRY_SIZE) + 1,
    localparam int GRP_ID_W      = (DISP_SIZE > 1) ? $clog2(DISP_SIZE) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic                             i_disp_valid,
    input  logic [DISP_SIZE-1:0]             i_disp_grp_valid,
    input  logic [DISP_SIZE-1:0]             i_disp_old_rd_valid,
    input  logic [DISP_SIZE*RNID_W-1:0]      i_disp_old_rd_rnid,
    output logic                             o_disp_ready,
    output logic [CMT_ID_W-1:0]              o_new_cmt_id,
    input  logic [CMT_BUS_SIZE-1:0]          i_done_valid,
    input  logic [CMT_BUS_SIZE*CMT_ID_W-1:0] i_done_cmt_id,
    input  logic [CMT_BUS_SIZE*GRP_ID_W-1:0] i_done_grp_id,
    input  logic [CMT_BUS_SIZE-1:0]          i_done_except,
    output logic                             o_commit_valid,
    output logic [CMT_ID_W-1:0]              o_commit_cmt_id,
    output logic [DISP_SIZE-1:0]             o_commit_grp_valid,
    output logic [DISP_SIZE-1:0]             o_commit_old_rd_valid,
    output logic [DISP_SIZE*RNID_W-1:0]      o_commit_old_rd_rnid,
    output logic                             o_flush_valid,
    output logic [CMT_ID_W-1:0]              o_flush_cmt_id
);
    localparam int                  IDX_W    = CMT_ID_W - 1;
    localparam logic [CMT_ID_W-1:0] FULL_CNT = CMT_ID_W'(CMT_ENTRY_SIZE);
    localparam logic [GRP_ID_W:0]   SLOT_LIM = (GRP_ID_W + 1)'(DISP_SIZE);

    logic [CMT_ID_W-1:0] head, tail, count;
    logic                flush_pending;

    logic [CMT_ENTRY_SIZE-1:0]                       ent_valid;
    logic [CMT_ENTRY_SIZE-1:0][CMT_ID_W-1:0]         ent_id;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0]        ent_grp;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0]        ent_done;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0]        ent_except;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0]        ent_old_vld;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE*RNID_W-1:0] ent_old_rnid;

    logic [IDX_W-1:0] head_idx, tail_idx;
    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];

    logic                 disp_fire, commit_fire, flush_fire;
    logic [DISP_SIZE-1:0] h_done, h_except, retire;
    logic                 head_ready, exc_seen;

    assign h_done   = ent_done[head_idx];
    assign h_except = ent_except[head_idx];

    // Head is ready once every slot up to and including the first excepting
    // one is done; only slots strictly below that exception retire.
    always_comb begin
        head_ready = 1'b1;
        exc_seen   = 1'b0;
        retire     = '0;
        for (int s = 0; s < DISP_SIZE; s++) begin
            if (!exc_seen && !h_done[s]) head_ready = 1'b0;
            exc_seen  = exc_seen | h_except[s];
            retire[s] = !exc_seen;
        end
    end

    assign commit_fire = ent_valid[head_idx] && head_ready && !flush_pending;
    assign flush_fire  = commit_fire && (|h_except);

    assign o_disp_ready = (count != FULL_CNT) && !flush_pending;
    assign disp_fire    = i_disp_valid && (|i_disp_grp_valid) && o_disp_ready;
    assign o_new_cmt_id = tail;

    assign o_commit_valid        = commit_fire;
    assign o_commit_cmt_id       = commit_fire ? head : '0;
    assign o_commit_grp_valid    = commit_fire ? (ent_grp[head_idx] & retire) : '0;
    assign o_commit_old_rd_valid = o_commit_grp_valid & ent_old_vld[head_idx];
    assign o_commit_old_rd_rnid  = commit_fire ? ent_old_rnid[head_idx] : '0;
    assign o_flush_valid         = flush_fire;
    assign o_flush_cmt_id        = flush_fire ? head : '0;

    logic [CMT_BUS_SIZE-1:0][CMT_ID_W-1:0]    rep_id;
    logic [CMT_BUS_SIZE-1:0][GRP_ID_W-1:0]    rep_slot;
    logic [CMT_BUS_SIZE-1:0]                  rep_hit;
    logic [CMT_ENTRY_SIZE-1:0][DISP_SIZE-1:0] done_set, exc_set;

    // A report must match the full stored id so a stale, wrapped id is dropped.
    generate
        for (genvar c = 0; c < CMT_BUS_SIZE; c++) begin : g_rep
            assign rep_id[c]   = i_done_cmt_id[c*CMT_ID_W +: CMT_ID_W];
            assign rep_slot[c] = i_done_grp_id[c*GRP_ID_W +: GRP_ID_W];
            assign rep_hit[c]  = i_done_valid[c] && !flush_fire
                              && ent_valid[rep_id[c][IDX_W-1:0]]
                              && (ent_id[rep_id[c][IDX_W-1:0]] == rep_id[c])
                              && ({1'b0, rep_slot[c]} < SLOT_LIM);
        end
    endgenerate

    always_comb begin
        done_set = '0;
        exc_set  = '0;
        for (int c = 0; c < CMT_BUS_SIZE; c++) begin
            if (rep_hit[c]) begin
                done_set[rep_id[c][IDX_W-1:0]][rep_slot[c]] = 1'b1;
                exc_set[rep_id[c][IDX_W-1:0]][rep_slot[c]] =
                    exc_set[rep_id[c][IDX_W-1:0]][rep_slot[c]] | i_done_except[c];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            flush_pending <= 1'b0;
            ent_valid     <= '0;
            ent_id        <= '0;
            ent_grp       <= '0;
            ent_done      <= '0;
            ent_except    <= '0;
            ent_old_vld   <= '0;
            ent_old_rnid  <= '0;
        end else if (flush_pending) begin
            // head already points past the excepting group
            ent_valid     <= '0;
            tail          <= head;
            count         <= '0;
            flush_pending <= 1'b0;
        end else begin
            ent_done   <= ent_done | done_set;
            ent_except <= ent_except | exc_set;
            if (disp_fire) begin
                ent_valid[tail_idx]    <= 1'b1;
                ent_id[tail_idx]       <= tail;
                ent_grp[tail_idx]      <= i_disp_grp_valid;
                ent_done[tail_idx]     <= ~i_disp_grp_valid;
                ent_except[tail_idx]   <= '0;
                ent_old_vld[tail_idx]  <= i_disp_old_rd_valid;
                ent_old_rnid[tail_idx] <= i_disp_old_rd_rnid;
                tail                   <= tail + 1'b1;
            end
            if (commit_fire) begin
                ent_valid[head_idx] <= 1'b0;
                head                <= head + 1'b1;
            end
            if (flush_fire) flush_pending <= 1'b1;
            if (disp_fire && !commit_fire)      count <= count + 1'b1;
            else if (!disp_fire && commit_fire) count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_msrh_cmt_tracker.sv
// Bench for msrh_cmt_tracker: directed scenarios plus random traffic checked
// against a queue-based model of in-order groups.
module tb_msrh_cmt_tracker;
    localparam int DS = 2, NENT = 16, BUS = 2, RW = 6, IDW = 5, GW = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              disp_valid;
    logic [DS-1:0]     disp_grp, disp_ov;
    logic [DS*RW-1:0]  disp_rn;
    logic              disp_ready;
    logic [IDW-1:0]    new_cmt_id;
    logic [BUS-1:0]    done_valid, done_except;
    logic [BUS*IDW-1:0] done_cmt_id;
    logic [BUS*GW-1:0] done_grp_id;
    logic              commit_valid, flush_valid;
    logic [IDW-1:0]    commit_cmt_id, flush_cmt_id;
    logic [DS-1:0]     commit_grp, commit_ov;
    logic [DS*RW-1:0]  commit_rn;

    msrh_cmt_tracker #(.DISP_SIZE(DS), .CMT_ENTRY_SIZE(NENT), .CMT_BUS_SIZE(BUS), .RNID_W(RW)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_disp_valid(disp_valid), .i_disp_grp_valid(disp_grp),
        .i_disp_old_rd_valid(disp_ov), .i_disp_old_rd_rnid(disp_rn),
        .o_disp_ready(disp_ready), .o_new_cmt_id(new_cmt_id),
        .i_done_valid(done_valid), .i_done_cmt_id(done_cmt_id),
        .i_done_grp_id(done_grp_id), .i_done_except(done_except),
        .o_commit_valid(commit_valid), .o_commit_cmt_id(commit_cmt_id),
        .o_commit_grp_valid(commit_grp), .o_commit_old_rd_valid(commit_ov),
        .o_commit_old_rd_rnid(commit_rn),
        .o_flush_valid(flush_valid), .o_flush_cmt_id(flush_cmt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0]   id;
        logic [DS-1:0]    grp, done, exc, ov;
        logic [DS*RW-1:0] rn;
    } ent_t;

    ent_t           q[$];
    logic [IDW-1:0] m_tail, m_head;
    bit             m_fp;
    bit             e_ready, e_cv, e_fl;
    logic [DS-1:0]  e_grp, e_ov;
    logic [DS*RW-1:0] e_rn;
    logic [IDW-1:0] e_cid;
    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        disp_valid = 1'b0; disp_grp = '0; disp_ov = '0; disp_rn = '0;
        done_valid = '0; done_cmt_id = '0; done_grp_id = '0; done_except = '0;
    endtask

    task automatic disp(input logic [DS-1:0] grp, input logic [DS-1:0] ov, input logic [DS*RW-1:0] rn);
        disp_valid = 1'b1; disp_grp = grp; disp_ov = ov; disp_rn = rn;
    endtask

    task automatic rep(input int ch, input logic [IDW-1:0] id, input logic slot, input logic exc);
        done_valid[ch] = 1'b1;
        done_cmt_id[ch*IDW +: IDW] = id;
        done_grp_id[ch] = slot;
        done_except[ch] = exc;
    endtask

    task automatic model_reset();
        q.delete(); m_tail = '0; m_head = '0; m_fp = 0;
    endtask

    // Oldest group commits once every slot up to its first exception is done.
    task automatic model_eval();
        int first;
        bit ok;
        e_ready = (q.size() < NENT) && !m_fp;
        e_cv = 0; e_fl = 0; e_grp = '0; e_ov = '0; e_rn = '0; e_cid = '0;
        if (!m_fp && q.size() > 0) begin
            first = DS;
            for (int s = DS - 1; s >= 0; s--) if (q[0].exc[s]) first = s;
            ok = 1;
            for (int s = 0; s < DS; s++) if (s <= first && !q[0].done[s]) ok = 0;
            if (ok) begin
                e_cv = 1; e_cid = q[0].id; e_rn = q[0].rn; e_fl = (first < DS);
                for (int s = 0; s < DS; s++) if (s < first) e_grp[s] = q[0].grp[s];
                e_ov = e_grp & q[0].ov;
            end
        end
    endtask

    task automatic model_update();
        ent_t t;
        if (m_fp) begin
            q.delete(); m_tail = m_head; m_fp = 0;
            return;
        end
        if (!e_fl)
            for (int c = 0; c < BUS; c++)
                if (done_valid[c])
                    for (int i = 0; i < q.size(); i++)
                        if (q[i].id == done_cmt_id[c*IDW +: IDW]) begin
                            t = q[i];
                            t.done[done_grp_id[c]] = 1'b1;
                            t.exc[done_grp_id[c]]  = t.exc[done_grp_id[c]] | done_except[c];
                            q[i] = t;
                        end
        if (e_cv) begin
            void'(q.pop_front());
            m_head = m_head + 1'b1;
            m_fp = e_fl;
        end
        if (disp_valid && (disp_grp != '0) && e_ready) begin
            t.id = m_tail; t.grp = disp_grp; t.done = ~disp_grp; t.exc = '0;
            t.ov = disp_ov; t.rn = disp_rn;
            q.push_back(t);
            m_tail = m_tail + 1'b1;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_eval();
        chk("ready", 32'(disp_ready), 32'(e_ready));
        chk("new_id", 32'(new_cmt_id), 32'(m_tail));
        chk("commit_valid", 32'(commit_valid), 32'(e_cv));
        chk("flush_valid", 32'(flush_valid), 32'(e_fl));
        if (e_cv) begin
            chk("commit_id", 32'(commit_cmt_id), 32'(e_cid));
            chk("commit_grp", 32'(commit_grp), 32'(e_grp));
            chk("commit_ov", 32'(commit_ov), 32'(e_ov));
            chk("commit_rn", 32'(commit_rn), 32'(e_rn));
        end
        if (e_fl) chk("flush_id", 32'(flush_cmt_id), 32'(e_cid));
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cycle();
        at_neg();
        finish_cycle();
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_ready", 32'(disp_ready), 32'd1);
        chk("rst_new_id", 32'(new_cmt_id), 32'd0);
        chk("rst_commit", 32'(commit_valid), 32'd0);
        chk("rst_flush", 32'(flush_valid), 32'd0);
        chk("rst_grp", 32'(commit_grp), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        logic [IDW-1:0] rid;
        idle();
        do_reset();

        // out-of-order dones, in-order commits
        for (int i = 0; i < 3; i++) begin idle(); disp(2'b11, 2'b00, 12'h0); cycle(); end
        idle(); rep(0, 5'd2, 1'b0, 1'b0); rep(1, 5'd2, 1'b1, 1'b0); cycle();
        idle(); rep(0, 5'd1, 1'b0, 1'b0); rep(1, 5'd1, 1'b1, 1'b0); cycle();
        idle(); rep(0, 5'd0, 1'b0, 1'b0); rep(1, 5'd0, 1'b1, 1'b0); cycle();
        idle();
        at_neg(); chk("s1_commit0", 32'(commit_cmt_id), 32'd0); chk("s1_grp0", 32'(commit_grp), 32'b11); finish_cycle();
        at_neg(); chk("s1_commit1", 32'(commit_cmt_id), 32'd1); finish_cycle();
        at_neg(); chk("s1_commit2", 32'(commit_cmt_id), 32'd2); finish_cycle();
        cycle();

        // fill to capacity, id wrap, ready restored by one commit
        do_reset();
        for (int i = 0; i < 15; i++) begin idle(); disp(2'b11, 2'b00, 12'h0); cycle(); end
        idle(); disp(2'b11, 2'b00, 12'h0);
        at_neg(); chk("s2_id15", 32'(new_cmt_id), 32'h0F); finish_cycle();
        rep(0, 5'd0, 1'b0, 1'b0); rep(1, 5'd0, 1'b1, 1'b0);
        at_neg(); chk("s2_full_rdy", 32'(disp_ready), 32'd0); chk("s2_wrap_id", 32'(new_cmt_id), 32'h10); finish_cycle();
        idle(); disp(2'b11, 2'b00, 12'h0); cycle();
        at_neg(); chk("s2_rdy_back", 32'(disp_ready), 32'd1); finish_cycle();
        idle(); cycle();

        // partial group with old rd release
        do_reset();
        idle(); disp(2'b01, 2'b01, {6'd33, 6'd12}); cycle();
        idle(); rep(0, 5'd0, 1'b0, 1'b0); cycle();
        idle();
        at_neg();
        chk("s3_grp", 32'(commit_grp), 32'b01);
        chk("s3_ov", 32'(commit_ov), 32'b01);
        chk("s3_rn", 32'(commit_rn[5:0]), 32'd12);
        finish_cycle();

        // exception in slot 1 of entry 1 flushes
        do_reset();
        for (int i = 0; i < 4; i++) begin idle(); disp(2'b11, 2'b11, 12'($urandom)); cycle(); end
        idle(); rep(0, 5'd0, 1'b0, 1'b0); rep(1, 5'd0, 1'b1, 1'b0); cycle();
        idle(); rep(0, 5'd1, 1'b0, 1'b0); rep(1, 5'd1, 1'b1, 1'b1); cycle();
        idle(); rep(0, 5'd2, 1'b0, 1'b0); rep(1, 5'd2, 1'b1, 1'b0);
        at_neg();
        chk("s4_flush", 32'(flush_valid), 32'd1);
        chk("s4_flush_id", 32'(flush_cmt_id), 32'd1);
        chk("s4_grp", 32'(commit_grp), 32'b01);
        finish_cycle();
        idle(); disp(2'b11, 2'b00, 12'h0); rep(0, 5'd3, 1'b0, 1'b0); rep(1, 5'd3, 1'b1, 1'b0);
        at_neg(); chk("s4_pend_rdy", 32'(disp_ready), 32'd0); finish_cycle();
        idle();
        at_neg(); chk("s4_new_id", 32'(new_cmt_id), 32'd2); chk("s4_no_commit", 32'(commit_valid), 32'd0); finish_cycle();

        // stale wrap-bit done is ignored
        do_reset();
        idle(); disp(2'b11, 2'b00, 12'h0); cycle();
        idle(); rep(0, 5'h10, 1'b0, 1'b0); rep(1, 5'h10, 1'b1, 1'b0); cycle();
        idle();
        at_neg(); chk("s5_stale", 32'(commit_valid), 32'd0); finish_cycle();
        rep(0, 5'h00, 1'b0, 1'b0); rep(1, 5'h00, 1'b1, 1'b0); cycle();
        idle();
        at_neg(); chk("s6_same_entry", 32'(commit_valid), 32'd1); finish_cycle();

        // random traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            if ($urandom_range(0, 2) != 0)
                disp(DS'($urandom), DS'($urandom), (DS*RW)'($urandom));
            for (int c = 0; c < BUS; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    if (q.size() > 0 && $urandom_range(0, 5) != 0)
                        rid = q[$urandom_range(0, q.size() - 1)].id;
                    else
                        rid = IDW'($urandom);
                    rep(c, rid, 1'($urandom), ($urandom_range(0, 15) == 0));
                end
            end
            cycle();
        end

        do_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msrh_cmt_tracker.md
Name: msrh_cmt_tracker

Overview:
- Parametrised commit tracker (reorder buffer) for the msrh core; successor to the fixed-size tile-level ROB.
- One entry per dispatch group from rename. Done reports from N execution pipes mark slots complete. Groups commit in order, one group per cycle.
- Adds exception-driven flush and old-rd release on commit, which the current ROB does not provide.

Parameters:
- DISP_SIZE, 2, instruction slots per dispatch group.
- CMT_ENTRY_SIZE, 16, entries; power of two, >=4.
- CMT_BUS_SIZE, 2, done-report channels per cycle.
- RNID_W, 6, physical register id width.
- Derived: CMT_ID_W = $clog2(CMT_ENTRY_SIZE)+1 (MSB = wrap bit); GRP_ID_W = max(1,$clog2(DISP_SIZE)).

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_disp_valid  in  1  dispatch group present.
- i_disp_grp_valid  in  DISP_SIZE  per-slot valid.
- i_disp_old_rd_valid  in  DISP_SIZE  slot frees an old physical rd at commit.
- i_disp_old_rd_rnid  in  DISP_SIZE*RNID_W  old rd ids, slot 0 in LSBs.
- o_disp_ready  out  1  tracker accepts a group this cycle.
- o_new_cmt_id  out  CMT_ID_W  id given to the group dispatched this cycle (tail pointer).
- i_done_valid  in  CMT_BUS_SIZE  done report per channel.
- i_done_cmt_id  in  CMT_BUS_SIZE*CMT_ID_W  target entry.
- i_done_grp_id  in  CMT_BUS_SIZE*GRP_ID_W  target slot.
- i_done_except  in  CMT_BUS_SIZE  reported instruction raised an exception.
- o_commit_valid  out  1  head group commits this cycle.
- o_commit_cmt_id  out  CMT_ID_W  committing entry id.
- o_commit_grp_valid  out  DISP_SIZE  slots actually retired.
- o_commit_old_rd_valid  out  DISP_SIZE  old rd frees, masked by o_commit_grp_valid.
- o_commit_old_rd_rnid  out  DISP_SIZE*RNID_W  old rd ids.
- o_flush_valid  out  1  pipeline flush pulse.
- o_flush_cmt_id  out  CMT_ID_W  id of the excepting entry.

Behaviour:
- Reset (async): head = tail = 0, count = 0, all entry valid/done/except bits cleared. All outputs are 0 while in reset and in the first cycle after it; o_disp_ready = 1.
- Dispatch:
  - A group is accepted when i_disp_valid && |i_disp_grp_valid && o_disp_ready.
  - Accepted group writes entry[tail]: done = ~grp_valid (unused slots pre-done), except = 0. Tail increments with wrap into the MSB.
  - A group with all slot valids 0 is ignored.
- o_disp_ready = (count != CMT_ENTRY_SIZE) && !flush_pending. Ready does not consider a commit in the same cycle, so a full buffer never accepts a group.
- Done reports:
  - Each channel sets done[slot] and ORs except into except[slot] of entry[cmt_id low bits], applied at the clock edge.
  - A report is ignored if the entry is invalid or its full cmt_id (including the wrap bit) does not match the stored id.
  - Multiple channels may report the same entry in one cycle; all are applied.
- Commit (combinational from entry state; a done report in cycle N gives commit in N+1 at the earliest):
  - Head commits when it is valid and either all slots are done, or the lowest excepting slot and every slot below it are done.
  - o_commit_grp_valid = grp_valid masked to the slots strictly below the first excepting slot. The excepting instruction itself does not retire.
  - Head increments and count decrements at the edge. Dispatch and commit may occur in the same cycle; count stays unchanged in that case.
- Flush:
  - When the committing head has any except bit set, o_flush_valid = 1 and o_flush_cmt_id = head id in the same cycle.
  - flush_pending is set at that edge. In the following cycle all entries are invalidated, tail = head (already advanced), count = 0, and flush_pending clears.
  - Dispatch is blocked during flush_pending. Done reports that arrive in the flush cycle or in the flush_pending cycle are discarded.
- Asserting reset mid-operation restores the reset state immediately.

Test Plan:
- Reset, then dispatch 3 full groups (grp_valid=2'b11); report dones out of order, entry 2 first, then entries 1 and 0 -> commits occur in id order 0,1,2, one per cycle, each with grp_valid=2'b11; the first commit appears in the cycle after the entry-0 done.
- Fill 16 groups without any done -> o_disp_ready drops after the 16th accept, and o_new_cmt_id wraps from 5'h0F to 5'h10; a single commit then restores ready the next cycle.
- Dispatch grp_valid=2'b01 with old_rd_valid=2'b01, rnid=6'd12; report slot 0 done -> commit with grp_valid=2'b01, old_rd_valid=2'b01, old_rd_rnid[5:0]=12.
- Dispatch entries 0–3; report slot 1 of entry 1 with except=1, plus all other dones -> entry 0 commits, then entry 1 commits with grp_valid=2'b01 and o_flush_valid=1, flush_cmt_id=1. The next cycle count=0, and the next o_new_cmt_id=2.
- Send a stale done whose id has the wrap bit mismatched against a live entry -> no done bit set and no commit.
- Two channels report both slots of the same head entry in one cycle -> commit occurs the next cycle.
